// File: rtl/ddr3_rd_capture_ctrl_if.sv
// Signal bundle between the DDR3 read-capture controller, the PHY command side
// and the 8-deep capture ring buffer.
interface ddr3_rd_capture_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              rd_issue;
  logic [4:0]        rd_latency;
  logic [DATA_W-1:0] rb_dout;
  logic              listen;
  logic [2:0]        readPtr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_err;
  logic              busy;

  modport slave (
    input  rd_issue, rd_latency, rb_dout,
    output listen, readPtr, rd_data, rd_valid, rd_last, rd_err, busy
  );

  modport master (
    output rd_issue, rd_latency, rb_dout,
    input  listen, readPtr, rd_data, rd_valid, rd_last, rd_err, busy
  );
endinterface

// File: rtl/ddr3_rd_capture_ctrl.sv
// Times the capture-window listen pulse for each BL8 read and drains the
// eight captured beats from the ring buffer as a valid-qualified stream.
module ddr3_rd_capture_ctrl #(
  parameter int DATA_W  = 16,
  parameter int NSLOT   = 4,
  parameter int SYNC    = 2,
  parameter int MIN_GAP = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  ddr3_rd_capture_ctrl_if.slave  bus
);

  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int GAP_W  = $clog2(MIN_GAP + 1);
  localparam logic [5:0] LISTEN_AT = 6'(SYNC + 6);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            r_state, w_stateNext;
  logic [NSLOT-1:0]  r_slotValid;
  logic [5:0]        r_timer [NSLOT];
  logic [GAP_W-1:0]  r_gap;
  logic              r_pending, w_pendingNext;
  logic [2:0]        r_readPtr, w_ptrNext;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid, r_rdLast, r_rdErr, r_listen;

  logic [SLOT_W-1:0] w_allocIdx;
  logic              w_anyFree, w_accept, w_gapOk, w_drainReq, w_listenNext;
  logic              w_capture, w_last;
  logic [NSLOT-1:0]  w_fire;
  logic [4:0]        w_rl;
  logic [5:0]        w_load;

  // Timer counts down from RL+SYNC+3 so it reaches 0 exactly on the drain-request cycle.
  assign w_rl     = (bus.rd_latency < 5'd4) ? 5'd4 : bus.rd_latency;
  assign w_load   = 6'(w_rl) + 6'(SYNC + 3);
  assign w_gapOk  = (r_gap >= GAP_W'(MIN_GAP));
  assign w_accept = bus.rd_issue && w_anyFree && w_gapOk;

  always_comb begin
    w_allocIdx   = '0;
    w_anyFree    = 1'b0;
    w_fire       = '0;
    w_listenNext = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!r_slotValid[i]) begin
        w_allocIdx = SLOT_W'(i);
        w_anyFree  = 1'b1;
      end
      w_fire[i] = r_slotValid[i] && (r_timer[i] == 6'd0);
      if (r_slotValid[i] && (r_timer[i] == LISTEN_AT)) w_listenNext = 1'b1;
    end
  end

  assign w_drainReq = |w_fire;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSLOT; i++) begin
      if (reset || w_fire[i]) begin
        r_slotValid[i] <= 1'b0;
        r_timer[i]     <= 6'd0;
      end else if (w_accept && (w_allocIdx == SLOT_W'(i))) begin
        r_slotValid[i] <= 1'b1;
        r_timer[i]     <= w_load;
      end else if (r_slotValid[i]) begin
        r_timer[i]     <= r_timer[i] - 6'd1;
      end
    end
  end

  // Gap counter only restarts on an accepted issue and saturates at MIN_GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap    <= GAP_W'(MIN_GAP);
      r_rdErr  <= 1'b0;
      r_listen <= 1'b0;
    end else begin
      if (w_accept)                         r_gap <= GAP_W'(1);
      else if (r_gap < GAP_W'(MIN_GAP))     r_gap <= r_gap + GAP_W'(1);
      r_rdErr  <= bus.rd_issue && !w_accept;
      r_listen <= w_listenNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_ptrNext     = 3'd0;
    w_capture     = 1'b0;
    w_last        = 1'b0;
    w_pendingNext = r_pending;
    case (r_state)
      S_IDLE: begin
        if (w_drainReq || r_pending) begin
          w_stateNext   = S_DRAIN;
          w_ptrNext     = 3'd1;
          w_capture     = 1'b1;
          w_pendingNext = r_pending && w_drainReq;
        end
      end
      S_DRAIN: begin
        w_capture = 1'b1;
        if (w_drainReq) w_pendingNext = 1'b1;
        if (r_readPtr == 3'd7) begin
          w_last      = 1'b1;
          w_stateNext = S_IDLE;
        end else begin
          w_ptrNext   = r_readPtr + 3'd1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // rd_data captures rb_dout for the pointer presented during the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_readPtr <= 3'd0;
      r_pending <= 1'b0;
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
      r_rdLast  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_readPtr <= w_ptrNext;
      r_pending <= w_pendingNext;
      r_rdValid <= w_capture;
      r_rdLast  <= w_last;
      if (w_capture) r_rdData <= bus.rb_dout;
    end
  end

  assign bus.listen   = r_listen;
  assign bus.readPtr  = r_readPtr;
  assign bus.rd_data  = r_rdData;
  assign bus.rd_valid = r_rdValid;
  assign bus.rd_last  = r_rdLast;
  assign bus.rd_err   = r_rdErr;
  assign bus.busy     = (|r_slotValid) || (r_state != S_IDLE) || r_rdValid || r_pending;

endmodule

// File: tb/tb_ddr3_rd_capture_ctrl.sv
// Directed bench for ddr3_rd_capture_ctrl: one task per scenario, cycle-indexed
// hand-computed expectations, plus a burst-length monitor.
module tb_ddr3_rd_capture_ctrl;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   runLen = 0;

  ddr3_rd_capture_ctrl_if #(.DATA_W(DATA_W)) bus ();
  ddr3_rd_capture_ctrl_if #(.DATA_W(DATA_W)) bus2 ();

  ddr3_rd_capture_ctrl #(.DATA_W(DATA_W), .NSLOT(4), .SYNC(2), .MIN_GAP(12)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  ddr3_rd_capture_ctrl #(.DATA_W(DATA_W), .NSLOT(2), .SYNC(2), .MIN_GAP(12)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  // Ring buffer stand-in: entry k holds 0xA000 + k.
  assign bus.rb_dout  = 16'hA000 | {13'd0, bus.readPtr};
  assign bus2.rb_dout = 16'hA000 | {13'd0, bus2.readPtr};

  // Every burst must be exactly 8 contiguous beats ending in rd_last.
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      runLen = runLen + 1;
      if (runLen > 8) begin
        total++; bad++;
        $display("[TB] FAIL burst_len run=%0d max=8 (drain overlapped)", runLen);
      end
      if (bus.rd_last) begin
        total++;
        if (runLen != 8) begin
          bad++;
          $display("[TB] FAIL last_pos got_beats=%0d want=8", runLen);
        end
      end
    end else begin
      if (bus.rd_last) begin
        total++; bad++;
        $display("[TB] FAIL last_without_valid got=1 want=0");
      end
      runLen = 0;
    end
  end

  function automatic int beatOf(int c, int first);
    if (c >= first && c < first + 8) return c - first;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.rd_issue = 1'b0;  bus.rd_latency = 5'd5;
    bus2.rd_issue = 1'b0; bus2.rd_latency = 5'd5;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    total += 7;
    if (bus.listen !== 1'b0)    begin bad++; $display("[TB] FAIL rst_listen got=%0b want=0", bus.listen); end
    if (bus.readPtr !== 3'd0)   begin bad++; $display("[TB] FAIL rst_ptr got=%0d want=0", bus.readPtr); end
    if (bus.rd_data !== 16'h0)  begin bad++; $display("[TB] FAIL rst_data got=%0h want=0", bus.rd_data); end
    if (bus.rd_valid !== 1'b0)  begin bad++; $display("[TB] FAIL rst_valid got=%0b want=0", bus.rd_valid); end
    if (bus.rd_last !== 1'b0)   begin bad++; $display("[TB] FAIL rst_last got=%0b want=0", bus.rd_last); end
    if (bus.rd_err !== 1'b0)    begin bad++; $display("[TB] FAIL rst_err got=%0b want=0", bus.rd_err); end
    if (bus.busy !== 1'b0)      begin bad++; $display("[TB] FAIL rst_busy got=%0b want=0", bus.busy); end
  endtask

  // RL=5, issue at 10: listen 14, ptr 0..7 on 21..28, valid 22..29, idle from 30.
  task automatic test_single();
    int b;
    doReset();
    for (int c = 0; c <= 34; c++) begin
      if (c > 0) step();
      bus.rd_issue = (c == 10);
      bus.rd_latency = 5'd5;
      b = beatOf(c, 22);
      total += 5;
      if (bus.listen !== (c == 14)) begin bad++; $display("[TB] FAIL single_listen cyc=%0d got=%0b want=%0b", c, bus.listen, (c == 14)); end
      if (bus.readPtr !== ((c >= 21 && c <= 28) ? 3'(c - 21) : 3'd0)) begin bad++; $display("[TB] FAIL single_ptr cyc=%0d got=%0d", c, bus.readPtr); end
      if (bus.rd_valid !== (b >= 0)) begin bad++; $display("[TB] FAIL single_valid cyc=%0d got=%0b want=%0b", c, bus.rd_valid, (b >= 0)); end
      if (bus.rd_last !== (c == 29)) begin bad++; $display("[TB] FAIL single_last cyc=%0d got=%0b", c, bus.rd_last); end
      if (bus.busy !== (c >= 11 && c <= 29)) begin bad++; $display("[TB] FAIL single_busy cyc=%0d got=%0b want=%0b", c, bus.busy, (c >= 11 && c <= 29)); end
      if (b >= 0) begin
        total++;
        if (bus.rd_data !== 16'hA000 + 16'(b)) begin bad++; $display("[TB] FAIL single_data cyc=%0d got=%0h want=%0h", c, bus.rd_data, 16'hA000 + 16'(b)); end
      end
    end
  endtask

  // RL=8, issues at 0 and 12: listen 7/19, bursts from 15 and 27, no errors.
  task automatic test_back_to_back();
    int b;
    doReset();
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) step();
      bus.rd_issue = (c == 0) || (c == 12);
      bus.rd_latency = 5'd8;
      b = (beatOf(c, 15) >= 0) ? beatOf(c, 15) : beatOf(c, 27);
      total += 3;
      if (bus.listen !== (c == 7 || c == 19)) begin bad++; $display("[TB] FAIL b2b_listen cyc=%0d got=%0b", c, bus.listen); end
      if (bus.rd_valid !== (b >= 0)) begin bad++; $display("[TB] FAIL b2b_valid cyc=%0d got=%0b want=%0b", c, bus.rd_valid, (b >= 0)); end
      if (bus.rd_err !== 1'b0) begin bad++; $display("[TB] FAIL b2b_err cyc=%0d got=%0b want=0", c, bus.rd_err); end
      if (b >= 0) begin
        total++;
        if (bus.rd_data !== 16'hA000 + 16'(b)) begin bad++; $display("[TB] FAIL b2b_data cyc=%0d got=%0h want=%0h", c, bus.rd_data, 16'hA000 + 16'(b)); end
      end
    end
  endtask

  // Issues at 0 and 5 with RL=5: second rejected, err at 6, single burst 12..19.
  task automatic test_gap();
    doReset();
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) step();
      bus.rd_issue = (c == 0) || (c == 5);
      bus.rd_latency = 5'd5;
      total += 3;
      if (bus.rd_err !== (c == 6)) begin bad++; $display("[TB] FAIL gap_err cyc=%0d got=%0b want=%0b", c, bus.rd_err, (c == 6)); end
      if (bus.listen !== (c == 4)) begin bad++; $display("[TB] FAIL gap_listen cyc=%0d got=%0b", c, bus.listen); end
      if (bus.rd_valid !== (c >= 12 && c <= 19)) begin bad++; $display("[TB] FAIL gap_valid cyc=%0d got=%0b", c, bus.rd_valid); end
    end
  endtask

  // RL=31, issues every 12 cycles: 4 slots accept all five; 2 slots reject 24 and 36.
  task automatic test_slots();
    bit expValid;
    doReset();
    for (int c = 0; c <= 95; c++) begin
      if (c > 0) step();
      bus.rd_issue  = (c % 12 == 0) && (c <= 48);
      bus2.rd_issue = bus.rd_issue;
      bus.rd_latency  = 5'd31;
      bus2.rd_latency = 5'd31;
      expValid = 1'b0;
      for (int k = 0; k < 5; k++) if (beatOf(c, 38 + 12 * k) >= 0) expValid = 1'b1;
      total += 4;
      if (bus.rd_err !== 1'b0) begin bad++; $display("[TB] FAIL slot4_err cyc=%0d got=%0b want=0", c, bus.rd_err); end
      if (bus.listen !== ((c >= 30) && (c <= 78) && ((c - 30) % 12 == 0))) begin bad++; $display("[TB] FAIL slot4_listen cyc=%0d got=%0b", c, bus.listen); end
      if (bus.rd_valid !== expValid) begin bad++; $display("[TB] FAIL slot4_valid cyc=%0d got=%0b want=%0b", c, bus.rd_valid, expValid); end
      if (bus2.rd_err !== (c == 25 || c == 37)) begin bad++; $display("[TB] FAIL slot2_err cyc=%0d got=%0b want=%0b", c, bus2.rd_err, (c == 25 || c == 37)); end
    end
    bus2.rd_issue = 1'b0;
  endtask

  // Reset during beat 3 of a burst aborts it; an issue 1 cycle later is accepted.
  task automatic test_reset_mid();
    int b;
    doReset();
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) step();
      reset = (c == 15);
      bus.rd_issue = (c == 0) || (c == 17);
      bus.rd_latency = 5'd5;
      b = (c >= 12 && c <= 15) ? c - 12 : beatOf(c, 29);
      total += 5;
      if (bus.rd_valid !== (b >= 0)) begin bad++; $display("[TB] FAIL rmid_valid cyc=%0d got=%0b want=%0b", c, bus.rd_valid, (b >= 0)); end
      if (bus.readPtr !== ((c >= 12 && c <= 15) ? 3'(c - 11) : (c >= 28 && c <= 35) ? 3'(c - 28) : 3'd0)) begin bad++; $display("[TB] FAIL rmid_ptr cyc=%0d got=%0d", c, bus.readPtr); end
      if (bus.busy !== ((c >= 1 && c <= 15) || (c >= 18 && c <= 36))) begin bad++; $display("[TB] FAIL rmid_busy cyc=%0d got=%0b", c, bus.busy); end
      if (bus.listen !== (c == 4 || c == 21)) begin bad++; $display("[TB] FAIL rmid_listen cyc=%0d got=%0b", c, bus.listen); end
      if (bus.rd_err !== 1'b0) begin bad++; $display("[TB] FAIL rmid_err cyc=%0d got=%0b want=0", c, bus.rd_err); end
      if (b >= 0) begin
        total++;
        if (bus.rd_data !== 16'hA000 + 16'(b)) begin bad++; $display("[TB] FAIL rmid_data cyc=%0d got=%0h want=%0h", c, bus.rd_data, 16'hA000 + 16'(b)); end
      end
    end
    reset = 1'b0;
  endtask

  // rd_latency=2 behaves as RL=4: listen at 3, valid 11..18, last at 18.
  task automatic test_clamp();
    doReset();
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) step();
      bus.rd_issue = (c == 0);
      bus.rd_latency = 5'd2;
      total += 3;
      if (bus.listen !== (c == 3)) begin bad++; $display("[TB] FAIL clamp_listen cyc=%0d got=%0b want=%0b", c, bus.listen, (c == 3)); end
      if (bus.rd_valid !== (c >= 11 && c <= 18)) begin bad++; $display("[TB] FAIL clamp_valid cyc=%0d got=%0b", c, bus.rd_valid); end
      if (bus.rd_last !== (c == 18)) begin bad++; $display("[TB] FAIL clamp_last cyc=%0d got=%0b", c, bus.rd_last); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_slots();
    test_reset_mid();
    test_clamp();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
